conversor_bases_seq: RTL and testbench
======================================

# conversor_bases_seq

Sequential, parametrised successor to the combinational base converter. Converts a LARGURA-bit binary value to NUM_DIGITOS digits in decimal, hexadecimal, octal or binary, and drives active-low 7-segment patterns for the board displays. Decimal uses an iterative double-dabble (shift-add-3) engine. Power-of-two bases are sliced directly. A start/busy/done handshake is added, plus signed-decimal and overflow reporting that the combinational converter lacks.

## Interface
- LARGURA, 8: input value width, 4..32.
- NUM_DIGITOS, 4: number of displayed digits, 1..16.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- inicio  in  1  conversion request.
- valor_binario  in  LARGURA  value to convert.
- base_selecionada  in  2  00 = decimal, 01 = hex, 10 = octal, 11 = binary.
- com_sinal  in  1  decimal only: treat the value as two's complement.
- ocupado  out  1  conversion in progress.
- pronto  out  1  one-cycle pulse when results update.
- estouro  out  1  nonzero digits exist beyond NUM_DIGITOS.
- negativo  out  1  decimal signed result was negative.
- digitos  out  4*NUM_DIGITOS  raw digit values; digit i at [4i+3:4i].
- HEX  out  7*NUM_DIGITOS  segment patterns, active-low, bit order gfedcba; digit i at [7i+6:7i].

## Operation
- FSM states: OCIOSO, CARGA, DESLOCA, FIM.
- OCIOSO: `inicio`=1 latches `valor_binario`, `base_selecionada` and `com_sinal`, then moves to CARGA.
- `inicio` is ignored in every state other than OCIOSO.
- CARGA, decimal:
  - If `com_sinal`=1 and the value's MSB=1, store the two's-complement magnitude and set an internal sign flag.
  - Clear the BCD register and load the shift counter with LARGURA.
  - Next state is DESLOCA.
- CARGA, other bases:
  - Slice digits directly: hex uses 4 bits per digit, octal 3 bits, binary 1 bit.
  - Slices are zero-extended to 4 bits; bits above LARGURA read as zero.
  - Next state is FIM.
- DESLOCA:
  - Each cycle, add 3 to every BCD nibble that is ≥5, then shift the magnitude MSB into the BCD register.
  - The counter decrements; after LARGURA shifts, next state is FIM.
- BCD register width is DIG_DEC(LARGURA) nibbles, where DIG_DEC = ceil(LARGURA·log10 2).
- FIM:
  - Commit the low NUM_DIGITOS digits to `digitos`.
  - `estouro` = any digit beyond NUM_DIGITOS is nonzero.
  - `negativo` = sign flag, forced to 0 for non-decimal bases.
  - Pulse `pronto` and return to OCIOSO.
- Output registers are double-buffered: `digitos`, `HEX`, `estouro` and `negativo` hold their previous values until FIM.
- `HEX` is decoded from `digitos` through the 0–F glyph set.
- Reset, whenever `rst_n`=0 at an edge (including mid-conversion):
  - state returns to OCIOSO;
  - `ocupado`, `pronto`, `estouro` and `negativo` go to 0;
  - `digitos` goes to 0 and every `HEX` digit shows 7'b1000000 ('0');
  - the partial result is discarded and no `pronto` is produced.

## Timing
- `inicio` sampled at edge E.
- `ocupado` is 1 from E+1 until the edge that executes FIM.
- Decimal: FIM executes at edge E+LARGURA+2. `pronto` and new outputs are visible after that edge (latency LARGURA+2; 10 cycles at the default).
- Hex, octal and binary: FIM executes at E+2 (latency 2).
- `pronto` and `ocupado` are registered.
- `inicio` asserted in the cycle where `pronto`=1 is accepted, giving back-to-back conversions.
- `HEX` is a combinational decode of registered `digitos`; no extra latency.

## Configuration
- CONVERSOR_SUPRIME_ZEROS_EN defined:
  - Leading zeros are blanked: every digit above the most significant nonzero digit shows 7'b1111111.
  - Digit 0 always shows; a value of 0 displays a single '0'.
  - The reset display is digit 0 = '0', all others blank.
- Undefined: all NUM_DIGITOS digits are displayed, including leading zeros.
- `digitos` is identical in both cases.

## Structure
- Package `conversor_pkg`:
  - base encoding constants BASE_DEC, BASE_HEX, BASE_OCT, BASE_BIN;
  - FSM state enum;
  - function DIG_DEC(width);
  - active-low segment constants SEG_APAGADO = 7'b1111111 and the 0–F glyphs.
- One sub-module, `bcd_ajuste_nibble`: the combinational add-3-if-≥5 cell, instantiated DIG_DEC times.
- The existing decoder `decodificador_7seg` is instantiated NUM_DIGITOS times.

## Test plan
All scenarios use LARGURA=8, NUM_DIGITOS=4.
- Decimal 8'd255 → `digitos`=0,2,5,5 (msd first); HEX2=7'b0100100, HEX1=HEX0=7'b0010010; `pronto` 10 cycles after `inicio`; `estouro`=0.
- Hex 8'hA7 → HEX1=7'b0001000 ('A'), HEX0=7'b1111000 ('7'); latency 2; HEX3/HEX2 are '0', or blank with the macro defined.
- Octal 8'd255 → digits 3,7,7 with HEX2=7'b0110000; binary 8'b10110001 → `digitos`=0,0,0,1 and `estouro`=1.
- Decimal 8'hF6 with `com_sinal`=1 → `digitos`=0,0,1,0 and `negativo`=1. The same input with `com_sinal`=0 → 2,4,6 and `negativo`=0.
- `inicio` pulsed at cycles 3 and 5 of a decimal conversion is ignored (one `pronto` only). `inicio` in the `pronto` cycle starts a second conversion.
- `rst_n`=0 at cycle 5 of a decimal conversion → next edge gives `ocupado`=0, `digitos`=0 and no `pronto` ever appears for that request.

Source files
------------

// File: rtl/conversor_pkg.sv
// Shared definitions for the sequential base converter: base codes, FSM states,
// decimal digit-count helper and active-low 7-segment glyphs (bit order gfedcba).
package conversor_pkg;

    localparam logic [1:0] BASE_DEC = 2'b00;
    localparam logic [1:0] BASE_HEX = 2'b01;
    localparam logic [1:0] BASE_OCT = 2'b10;
    localparam logic [1:0] BASE_BIN = 2'b11;

    typedef enum logic [1:0] {
        OCIOSO,
        CARGA,
        DESLOCA,
        FIM
    } estado_t;

    // ceil(largura * log10(2)); 0.30103 is accurate enough for widths up to 32
    function automatic int DIG_DEC(input int largura);
        return (largura * 30103 + 99999) / 100000;
    endfunction

    localparam logic [6:0] SEG_APAGADO = 7'b1111111;

    // Index d holds the glyph of hex digit d
    localparam logic [15:0][6:0] SEG_GLIFOS = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,   // F E d C
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,   // b A 9 8
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,   // 7 6 5 4
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000    // 3 2 1 0
    };

endpackage

// File: rtl/bcd_ajuste_nibble.sv
// Double-dabble correction cell: adds 3 to a BCD nibble that is 5 or more so the
// following left shift carries correctly into the next decimal digit.
module bcd_ajuste_nibble (
    input  logic [3:0] entrada,
    output logic [3:0] saida
);

    assign saida = (entrada >= 4'd5) ? entrada + 4'd3 : entrada;

endmodule

// File: rtl/decodificador_7seg.sv
// Hex digit to active-low 7-segment decoder (gfedcba), glyphs 0-F.
module decodificador_7seg
    import conversor_pkg::*;
(
    input  logic [3:0] digito,
    output logic [6:0] segmentos
);

    assign segmentos = SEG_GLIFOS[digito];

endmodule

// File: rtl/conversor_bases_seq.sv
// Sequential binary to decimal/hex/octal/binary converter with start/busy/done handshake.
// Define CONVERSOR_SUPRIME_ZEROS_EN to blank leading zeros on the 7-segment outputs.
module conversor_bases_seq
    import conversor_pkg::*;
#(
    parameter int LARGURA     = 8,
    parameter int NUM_DIGITOS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       inicio,
    input  logic [LARGURA-1:0]         valor_binario,
    input  logic [1:0]                 base_selecionada,
    input  logic                       com_sinal,
    output logic                       ocupado,
    output logic                       pronto,
    output logic                       estouro,
    output logic                       negativo,
    output logic [4*NUM_DIGITOS-1:0]   digitos,
    output logic [7*NUM_DIGITOS-1:0]   HEX
);

    localparam int ND  = DIG_DEC(LARGURA);
    // Binary needs one digit per input bit, so LARGURA digits cover every base
    localparam int TOT = (LARGURA > NUM_DIGITOS) ? LARGURA : NUM_DIGITOS;
    localparam int CW  = $clog2(LARGURA + 1);

    estado_t estado, prox_estado;

    logic [LARGURA-1:0] val_reg;
    logic [1:0]         base_reg;
    logic               sinal_en_reg;
    logic               sinal;
    logic [LARGURA-1:0] magnitude;
    logic [CW-1:0]      contador;
    logic [4*TOT-1:0]   acum;
    logic [4*TOT-1:0]   ext;
    logic [4*TOT-1:0]   fatias;
    logic [4*ND-1:0]    bcd_aj;
    logic               estouro_calc;
    logic [7*NUM_DIGITOS-1:0] seg_dec;

    always_ff @(posedge clk) begin
        if (!rst_n) estado <= OCIOSO;
        else        estado <= prox_estado;
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        prox_estado = estado;
        case (estado)
            OCIOSO:  if (inicio) prox_estado = CARGA;
            CARGA:   prox_estado = (base_reg == BASE_DEC) ? DESLOCA : FIM;
            DESLOCA: if (contador == CW'(1)) prox_estado = FIM;
            FIM:     prox_estado = OCIOSO;
            default: prox_estado = OCIOSO;
        endcase
    end

    generate
        for (genvar g = 0; g < ND; g++) begin : g_ajuste
            bcd_ajuste_nibble u_ajuste (
                .entrada (acum[4*g +: 4]),
                .saida   (bcd_aj[4*g +: 4])
            );
        end
    endgenerate

    // Power-of-two bases: slices of the zero-extended value, widened to 4 bits
    always_comb begin
        ext = '0;
        ext[LARGURA-1:0] = val_reg;
        fatias = '0;
        for (int i = 0; i < TOT; i++) begin
            case (base_reg)
                BASE_HEX: fatias[4*i +: 4] = ext[4*i +: 4];
                BASE_OCT: fatias[4*i +: 4] = {1'b0, ext[3*i +: 3]};
                default:  fatias[4*i +: 4] = {3'b000, ext[i]};
            endcase
        end
    end

    always_comb begin
        estouro_calc = 1'b0;
        for (int i = NUM_DIGITOS; i < TOT; i++)
            estouro_calc = estouro_calc | (acum[4*i +: 4] != 4'd0);
    end

    // NOTE: working registers carry no reset; each is loaded in CARGA before it is read.
    always_ff @(posedge clk) begin
        case (estado)
            OCIOSO: if (inicio) begin
                val_reg      <= valor_binario;
                base_reg     <= base_selecionada;
                sinal_en_reg <= com_sinal;
            end
            CARGA: begin
                if (base_reg == BASE_DEC) begin
                    acum     <= '0;
                    contador <= CW'(LARGURA);
                    if (sinal_en_reg && val_reg[LARGURA-1]) begin
                        magnitude <= -val_reg;
                        sinal     <= 1'b1;
                    end else begin
                        magnitude <= val_reg;
                        sinal     <= 1'b0;
                    end
                end else begin
                    acum  <= fatias;
                    sinal <= 1'b0;
                end
            end
            DESLOCA: begin
                // The bit landing in nibble ND is always 0: the result fits ND digits
                acum[4*ND:0] <= {bcd_aj, magnitude[LARGURA-1]};
                magnitude    <= magnitude << 1;
                contador     <= contador - 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ocupado  <= 1'b0;
            pronto   <= 1'b0;
            estouro  <= 1'b0;
            negativo <= 1'b0;
            digitos  <= '0;
        end else begin
            pronto <= 1'b0;
            if (estado == OCIOSO && inicio) ocupado <= 1'b1;
            if (estado == FIM) begin
                ocupado  <= 1'b0;
                pronto   <= 1'b1;
                digitos  <= acum[4*NUM_DIGITOS-1:0];
                estouro  <= estouro_calc;
                negativo <= sinal && (base_reg == BASE_DEC);
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_DIGITOS; g++) begin : g_display
            decodificador_7seg u_dec (
                .digito    (digitos[4*g +: 4]),
                .segmentos (seg_dec[7*g +: 7])
            );
        end
    endgenerate

`ifdef CONVERSOR_SUPRIME_ZEROS_EN
    // Blank every digit above the most significant nonzero one; digit 0 always shows
    always_comb begin
        logic zeros_acima;
        HEX = seg_dec;
        zeros_acima = 1'b1;
        for (int i = NUM_DIGITOS - 1; i > 0; i--) begin
            zeros_acima = zeros_acima && (digitos[4*i +: 4] == 4'd0);
            if (zeros_acima) HEX[7*i +: 7] = SEG_APAGADO;
        end
    end
`else
    assign HEX = seg_dec;
`endif

endmodule

// File: tb/tb_conversor_bases_seq.sv
// Self-checking bench for conversor_bases_seq (LARGURA=8, NUM_DIGITOS=4): arithmetic
// reference model checked every cycle, plus directed literal expectations.
module tb_conversor_bases_seq;

    localparam int L = 8;
    localparam int N = 4;

    localparam logic [6:0] GLIFO [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    localparam logic [6:0] ZERO7  = 7'b1000000;
    localparam logic [6:0] BLANK7 = 7'b1111111;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           inicio;
    logic [L-1:0]   valor_binario;
    logic [1:0]     base_selecionada;
    logic           com_sinal;
    logic           ocupado, pronto, estouro, negativo;
    logic [4*N-1:0] digitos;
    logic [7*N-1:0] HEX;

    int tests = 0;
    int fails = 0;
    logic chk_en = 1'b0;

    conversor_bases_seq #(.LARGURA(L), .NUM_DIGITOS(N)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .inicio           (inicio),
        .valor_binario    (valor_binario),
        .base_selecionada (base_selecionada),
        .com_sinal        (com_sinal),
        .ocupado          (ocupado),
        .pronto           (pronto),
        .estouro          (estouro),
        .negativo         (negativo),
        .digitos          (digitos),
        .HEX              (HEX)
    );

    always #5 clk = ~clk;

    task automatic check(input string nome, input logic [63:0] obtido, input logic [63:0] esperado);
        tests++;
        if (obtido !== esperado) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nome, obtido, esperado, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [15:0] dig;
        logic        est;
        logic        neg;
    } resultado_t;

    function automatic resultado_t modelo(input logic [7:0] v, input logic [1:0] b, input logic s);
        resultado_t r;
        int mag, rad, d;
        r.neg = (b == 2'b00) && s && v[7];
        mag = r.neg ? 256 - int'(v) : int'(v);
        rad = (b == 2'b00) ? 10 : (b == 2'b01) ? 16 : (b == 2'b10) ? 8 : 2;
        r.dig = '0;
        for (int i = 0; i < 4; i++) begin
            d = mag % rad;
            mag = mag / rad;
            r.dig[4*i +: 4] = 4'(d);
        end
        r.est = (mag != 0);
        return r;
    endfunction

    function automatic logic [27:0] hex_esperado(input logic [15:0] d);
        logic [27:0] h;
        bit acima;
        acima = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            h[7*i +: 7] = GLIFO[d[4*i +: 4]];
`ifdef CONVERSOR_SUPRIME_ZEROS_EN
            if (i > 0) begin
                acima = acima && (d[4*i +: 4] == 4'd0);
                if (acima) h[7*i +: 7] = BLANK7;
            end
`endif
        end
        return h;
    endfunction

    logic       m_busy, m_pronto, m_est, m_neg;
    logic [15:0] m_dig;
    int         m_cnt;
    resultado_t m_pend;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy   <= 1'b0;
            m_pronto <= 1'b0;
            m_dig    <= '0;
            m_est    <= 1'b0;
            m_neg    <= 1'b0;
            m_cnt    <= 0;
        end else begin
            m_pronto <= 1'b0;
            if (m_busy) begin
                if (m_cnt == 1) begin
                    m_busy   <= 1'b0;
                    m_pronto <= 1'b1;
                    m_dig    <= m_pend.dig;
                    m_est    <= m_pend.est;
                    m_neg    <= m_pend.neg;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end else if (inicio) begin
                m_pend <= modelo(valor_binario, base_selecionada, com_sinal);
                m_busy <= 1'b1;
                m_cnt  <= (base_selecionada == 2'b00) ? L + 2 : 2;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ocupado",  ocupado,  m_busy);
            check("pronto",   pronto,   m_pronto);
            check("digitos",  digitos,  m_dig);
            check("estouro",  estouro,  m_est);
            check("negativo", negativo, m_neg);
            check("hex",      HEX,      hex_esperado(m_dig));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic espera_pronto(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pronto && n < 40);
    endtask

    task automatic converte(input logic [7:0] v, input logic [1:0] b, input logic s, output int lat);
        @(negedge clk);
        inicio = 1'b1;
        valor_binario = v;
        base_selecionada = b;
        com_sinal = s;
        @(negedge clk);
        inicio = 1'b0;
        espera_pronto(lat);
    endtask

    task automatic conta_pronto(input int ciclos, output int k);
        k = 0;
        for (int i = 0; i < ciclos; i++) begin
            @(negedge clk);
            if (pronto) k++;
        end
    endtask

    logic [27:0] hex_rst;
    logic [13:0] hex_alto_a7;
    int lat, k;

    initial begin
`ifdef CONVERSOR_SUPRIME_ZEROS_EN
        hex_rst     = {BLANK7, BLANK7, BLANK7, ZERO7};
        hex_alto_a7 = {BLANK7, BLANK7};
`else
        hex_rst     = {ZERO7, ZERO7, ZERO7, ZERO7};
        hex_alto_a7 = {ZERO7, ZERO7};
`endif
        rst_n = 1'b0;
        inicio = 1'b0;
        valor_binario = '0;
        base_selecionada = 2'b00;
        com_sinal = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_ocupado", ocupado, 1'b0);
        check("rst_digitos", digitos, 16'h0000);
        check("rst_hex", HEX, hex_rst);
        rst_n = 1'b1;

        converte(8'd255, 2'b00, 1'b0, lat);
        check("dec255_lat", lat, 10);
        check("dec255_dig", digitos, 16'h0255);
        check("dec255_hex2", HEX[20:14], 7'b0100100);
        check("dec255_hex1", HEX[13:7], 7'b0010010);
        check("dec255_hex0", HEX[6:0], 7'b0010010);
        check("dec255_est", estouro, 1'b0);

        converte(8'hA7, 2'b01, 1'b0, lat);
        check("hexA7_lat", lat, 2);
        check("hexA7_hex1", HEX[13:7], 7'b0001000);
        check("hexA7_hex0", HEX[6:0], 7'b1111000);
        check("hexA7_alto", HEX[27:14], hex_alto_a7);

        converte(8'd255, 2'b10, 1'b0, lat);
        check("oct255_lat", lat, 2);
        check("oct255_dig", digitos, 16'h0377);
        check("oct255_hex2", HEX[20:14], 7'b0110000);

        converte(8'b10110001, 2'b11, 1'b0, lat);
        check("binB1_dig", digitos, 16'h0001);
        check("binB1_est", estouro, 1'b1);

        converte(8'hF6, 2'b00, 1'b1, lat);
        check("decF6s_dig", digitos, 16'h0010);
        check("decF6s_neg", negativo, 1'b1);
        converte(8'hF6, 2'b00, 1'b0, lat);
        check("decF6u_dig", digitos, 16'h0246);
        check("decF6u_neg", negativo, 1'b0);
        converte(8'h80, 2'b00, 1'b1, lat);
        check("dec80s_dig", digitos, 16'h0128);
        check("dec80s_neg", negativo, 1'b1);
        converte(8'hF6, 2'b01, 1'b1, lat);
        check("hexF6s_dig", digitos, 16'h00F6);
        check("hexF6s_neg", negativo, 1'b0);

        // inicio pulses while busy must be ignored
        @(negedge clk);
        inicio = 1'b1;
        valor_binario = 8'd42;
        base_selecionada = 2'b00;
        com_sinal = 1'b0;
        @(negedge clk);
        inicio = 1'b0;
        @(negedge clk);
        inicio = 1'b1;
        valor_binario = 8'd99;
        @(negedge clk);
        inicio = 1'b0;
        @(negedge clk);
        inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        espera_pronto(lat);
        check("ign_lat", lat, 6);
        check("ign_dig", digitos, 16'h0042);
        conta_pronto(15, k);
        check("ign_extra_pronto", k, 0);

        // back-to-back: inicio during the pronto cycle
        converte(8'd7, 2'b00, 1'b0, lat);
        check("b2b_first_dig", digitos, 16'h0007);
        inicio = 1'b1;
        valor_binario = 8'd200;
        @(negedge clk);
        inicio = 1'b0;
        espera_pronto(lat);
        check("b2b_lat", lat, 10);
        check("b2b_dig", digitos, 16'h0200);

        // reset in the middle of a decimal conversion
        @(negedge clk);
        inicio = 1'b1;
        valor_binario = 8'd255;
        @(negedge clk);
        inicio = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_ocupado", ocupado, 1'b0);
        check("midrst_dig", digitos, 16'h0000);
        check("midrst_hex", HEX, hex_rst);
        rst_n = 1'b1;
        conta_pronto(20, k);
        check("midrst_no_pronto", k, 0);

        converte(8'd0, 2'b00, 1'b0, lat);
        check("dec0_dig", digitos, 16'h0000);
        check("dec0_hex", HEX, hex_rst);

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
